// File: rtl/rv_fetch_pkg.sv
// Shared types and defaults for the RV32I instruction fetch stage.
package rv_fetch_pkg;
    localparam int               XLEN     = 32;
    localparam int               ADDR_W   = 8;
    localparam int               DEPTH    = 2;
    localparam logic [ADDR_W-1:0] RESET_PC = '0;
    localparam logic [XLEN-1:0]   NOP      = 32'h0000_0013;

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } fetch_state_t;

    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [XLEN-1:0]   instr;
    } fetch_entry_t;
endpackage

// File: rtl/rv_fetch_fifo.sv
// Small synchronous prefetch FIFO of {pc, instr} entries with a flush input.
// The head entry is read straight from the storage registers.
module rv_fetch_fifo #(
    parameter int  DEPTH = 2,
    parameter type T     = rv_fetch_pkg::fetch_entry_t
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clear,
    input  logic                       push,
    input  T                           push_data,
    input  logic                       pop,
    output T                           head,
    output logic                       empty,
    output logic                       full,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    import rv_fetch_pkg::*;

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);

    T              r_mem [DEPTH];
    logic [PW-1:0] r_wr;
    logic [PW-1:0] r_rd;
    logic [CW-1:0] r_count;
    logic          w_do_push;
    logic          w_do_pop;

    assign w_do_pop  = pop && (r_count != '0);
    assign w_do_push = push && ((r_count != CW'(DEPTH)) || w_do_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
        end else if (clear) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
        end else begin
            if (w_do_push) begin
                r_mem[r_wr] <= push_data;
                r_wr        <= r_wr + PW'(1);
            end
            if (w_do_pop) r_rd <= r_rd + PW'(1);
            r_count <= r_count + CW'(w_do_push) - CW'(w_do_pop);
        end
    end

    assign head  = r_mem[r_rd];
    assign empty = (r_count == '0);
    assign full  = (r_count == CW'(DEPTH));
    assign count = r_count;
endmodule

// File: rtl/rv_fetch_unit.sv
// Instruction fetch: credit-limited request stream, in-order tag queue, prefetch FIFO.
// States: RUN | issuing requests while credits allow;  HALT | no new requests, drain only.
module rv_fetch_unit #(
    parameter int                XLEN     = rv_fetch_pkg::XLEN,
    parameter int                ADDR_W   = rv_fetch_pkg::ADDR_W,
    parameter int                DEPTH    = rv_fetch_pkg::DEPTH,
    parameter logic [ADDR_W-1:0] RESET_PC = rv_fetch_pkg::RESET_PC
) (
    input  logic              clk,
    input  logic              rst,
    output logic              imem_req_valid,
    input  logic              imem_req_ready,
    output logic [ADDR_W-1:0] imem_req_addr,
    input  logic              imem_rsp_valid,
    input  logic [XLEN-1:0]   imem_rsp_data,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic [XLEN-1:0]   instr_data,
    output logic [ADDR_W-1:0] instr_pc,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    input  logic              halt
);
    import rv_fetch_pkg::*;

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);

    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [XLEN-1:0]   instr;
    } entry_t;

    fetch_state_t      r_state;
    fetch_state_t      w_state_next;
    logic [ADDR_W-1:0] r_pc;
    logic [CW-1:0]     r_inflight;
    logic [CW-1:0]     r_drop;
    logic [ADDR_W-1:0] r_tag [DEPTH];
    logic [PW-1:0]     r_tag_wr;
    logic [PW-1:0]     r_tag_rd;

    logic [CW-1:0]     w_count;
    logic              w_empty;
    logic              w_full;
    entry_t            w_head;
    entry_t            w_push_entry;
    logic              w_credit;
    logic              w_req_fire;
    logic              w_rsp_fire;
    logic              w_rsp_keep;
    logic              w_pop;

    // Dropped words keep their credit until they come back from memory.
    assign w_credit = ({1'b0, r_inflight} + {1'b0, w_count}) < (CW+1)'(DEPTH);

    // rst gating keeps the request low while reset is held; a redirect abandons
    // whatever was pending so nothing is accepted at the stale address.
    assign imem_req_valid = !rst && (r_state == RUN) && w_credit && !redirect_valid;
    assign imem_req_addr  = r_pc;

    assign w_req_fire = imem_req_valid && imem_req_ready;
    assign w_rsp_fire = imem_rsp_valid && (r_inflight != '0);
    assign w_rsp_keep = w_rsp_fire && (r_drop == '0) && !redirect_valid;
    assign w_pop      = !w_empty && instr_ready && !redirect_valid;

    assign w_push_entry = '{pc: r_tag[r_tag_rd], instr: imem_rsp_data};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= RUN;
        else     r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            RUN:     if (halt) w_state_next = HALT;
            HALT:    w_state_next = HALT;
            default: w_state_next = RUN;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc       <= RESET_PC;
            r_inflight <= '0;
            r_drop     <= '0;
            r_tag_wr   <= '0;
            r_tag_rd   <= '0;
            for (int i = 0; i < DEPTH; i++) r_tag[i] <= '0;
        end else begin
            r_inflight <= r_inflight + CW'(w_req_fire) - CW'(w_rsp_fire);
            if (redirect_valid) begin
                r_pc     <= redirect_pc;
                r_drop   <= r_inflight - CW'(w_rsp_fire);
                r_tag_wr <= '0;
                r_tag_rd <= '0;
            end else begin
                if (w_req_fire) begin
                    r_pc            <= r_pc + ADDR_W'(1);
                    r_tag[r_tag_wr] <= r_pc;
                    r_tag_wr        <= r_tag_wr + PW'(1);
                end
                if (w_rsp_fire) begin
                    if (r_drop != '0) r_drop   <= r_drop - CW'(1);
                    else              r_tag_rd <= r_tag_rd + PW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(imem_rsp_valid && r_inflight == '0))
                else $error("rv_fetch_unit: response with nothing in flight");
            assert (!(w_rsp_keep && w_full && !w_pop))
                else $error("rv_fetch_unit: push into full prefetch buffer");
        end
    end

    rv_fetch_fifo #(
        .DEPTH (DEPTH),
        .T     (entry_t)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .clear     (redirect_valid),
        .push      (w_rsp_keep),
        .push_data (w_push_entry),
        .pop       (w_pop),
        .head      (w_head),
        .empty     (w_empty),
        .full      (w_full),
        .count     (w_count)
    );

    assign instr_valid = !w_empty;
    assign instr_data  = w_head.instr;
    assign instr_pc    = w_head.pc;
endmodule

// File: tb/tb_rv_fetch_unit.sv
// Directed plus randomized bench for rv_fetch_unit against a queue-based memory
// and an in-order program-counter reference stream.
module tb_rv_fetch_unit;
    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [7:0]  imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr_data;
    logic [7:0]  instr_pc;
    logic        redirect_valid;
    logic [7:0]  redirect_pc;
    logic        halt;

    logic        w_req_valid;
    logic [7:0]  w_req_addr;
    logic        w_rsp_valid;
    logic [31:0] w_rsp_data;
    logic        w_instr_valid;
    logic [31:0] w_instr_data;
    logic [7:0]  w_instr_pc;

    logic [31:0] mem [256];
    logic [7:0]  pend_addr [$];
    int          pend_due [$];
    int          cyc = 0;
    int          m_d;
    bit          mem_rand = 1'b0;
    int          mem_delay = 0;
    logic        mem_ready_r = 1'b1;
    logic        ready_block = 1'b0;
    logic        w_pend;
    logic [7:0]  w_pend_addr;

    int          n_chk = 0;
    int          n_err = 0;
    int          n_acc = 0;
    int          n_deliv = 0;
    int          n_wdeliv = 0;
    int          scyc = 0;
    int          first_deliv = -1;
    int          snap;
    logic [7:0]  exp_pc;
    logic [7:0]  exp_wpc;

    always #5 clk = ~clk;

    assign imem_req_ready = mem_ready_r & ~ready_block;

    rv_fetch_unit #(.XLEN(32), .ADDR_W(8), .DEPTH(DEPTH), .RESET_PC(8'h00)) u_dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr_data     (instr_data),
        .instr_pc       (instr_pc),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .halt           (halt)
    );

    rv_fetch_unit #(.XLEN(32), .ADDR_W(8), .DEPTH(DEPTH), .RESET_PC(8'hFE)) u_wrap (
        .clk            (clk),
        .rst            (rst),
        .imem_req_valid (w_req_valid),
        .imem_req_ready (1'b1),
        .imem_req_addr  (w_req_addr),
        .imem_rsp_valid (w_rsp_valid),
        .imem_rsp_data  (w_rsp_data),
        .instr_valid    (w_instr_valid),
        .instr_ready    (1'b1),
        .instr_data     (w_instr_data),
        .instr_pc       (w_instr_pc),
        .redirect_valid (1'b0),
        .redirect_pc    (8'h00),
        .halt           (1'b0)
    );

    // In-order memory with configurable (fixed or random) response delay.
    initial begin
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (rst) begin
                pend_addr.delete();
                pend_due.delete();
                imem_rsp_valid = 1'b0;
            end else if (pend_due.size() > 0 && pend_due[0] <= cyc) begin
                imem_rsp_valid = 1'b1;
                imem_rsp_data  = mem[pend_addr[0]];
                void'(pend_addr.pop_front());
                void'(pend_due.pop_front());
            end else begin
                imem_rsp_valid = 1'b0;
                imem_rsp_data  = $urandom;
            end
            mem_ready_r = mem_rand ? ($urandom_range(0, 1) == 1) : 1'b1;
            @(negedge clk);
            if (!rst && imem_req_valid && imem_req_ready) begin
                m_d = mem_rand ? int'($urandom_range(0, mem_delay)) : mem_delay;
                pend_addr.push_back(imem_req_addr);
                pend_due.push_back(cyc + 1 + m_d);
                n_acc++;
            end
        end
    end

    // Zero-wait memory for the wrap instance.
    initial begin
        w_rsp_valid = 1'b0;
        w_rsp_data  = '0;
        forever begin
            @(negedge clk);
            w_pend      = !rst && w_req_valid;
            w_pend_addr = w_req_addr;
            @(posedge clk);
            #1;
            w_rsp_valid = w_pend && !rst;
            w_rsp_data  = mem[w_pend_addr];
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp)
            else begin
                n_err++;
                $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
            end
    endtask

    task automatic step();
        @(negedge clk);
        if (!rst && instr_valid && instr_ready && !redirect_valid) begin
            if (n_deliv == 0) first_deliv = scyc;
            chk("deliv_pc", 64'(instr_pc), 64'(exp_pc));
            chk("deliv_data", 64'(instr_data), 64'(mem[exp_pc]));
            exp_pc = exp_pc + 8'd1;
            n_deliv++;
        end
        if (!rst && w_instr_valid) begin
            chk("wrap_pc", 64'(w_instr_pc), 64'(exp_wpc));
            chk("wrap_data", 64'(w_instr_data), 64'(mem[exp_wpc]));
            exp_wpc = exp_wpc + 8'd1;
            n_wdeliv++;
        end
        scyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst            = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        halt           = 1'b0;
        ready_block    = 1'b0;
        #1;
        chk("rst_req_valid", 64'(imem_req_valid), 64'd0);
        chk("rst_req_addr", 64'(imem_req_addr), 64'h00);
        chk("rst_instr_valid", 64'(instr_valid), 64'd0);
        chk("rst_instr_data", 64'(instr_data), 64'd0);
        chk("rst_instr_pc", 64'(instr_pc), 64'd0);
        chk("rst_wrap_addr", 64'(w_req_addr), 64'hFE);
        repeat (2) @(posedge clk);
        n_acc       = 0;
        n_deliv     = 0;
        n_wdeliv    = 0;
        exp_pc      = 8'h00;
        exp_wpc     = 8'hFE;
        scyc        = 0;
        first_deliv = -1;
        #1;
        rst = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = $urandom;
        rst = 1'b0;
        instr_ready = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc = '0;
        halt = 1'b0;
        #2;

        // Zero-wait memory, core always ready; wrap instance runs alongside.
        do_reset();
        #1;
        chk("t1_req_valid", 64'(imem_req_valid), 64'd1);
        chk("t1_req_addr", 64'(imem_req_addr), 64'h00);
        chk("t1_instr_valid", 64'(instr_valid), 64'd0);
        for (int i = 0; i < 12 && n_deliv < 4; i++) step();
        chk("t1_four_delivered", 64'(n_deliv >= 4), 64'd1);
        chk("t1_latency", 64'(first_deliv), 64'd2);
        repeat (2) step();
        chk("t4_wrap_delivered", 64'(n_wdeliv >= 4), 64'd1);

        // Back-pressure: core stalls for 10 cycles.
        instr_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("t2_credit", 64'((n_acc - n_deliv) <= DEPTH), 64'd1);
        end
        chk("t2_req_stalled", 64'(imem_req_valid), 64'd0);
        chk("t2_buffered_valid", 64'(instr_valid), 64'd1);
        chk("t2_outstanding", 64'(n_acc - n_deliv), 64'(DEPTH));
        snap = n_deliv;
        instr_ready = 1'b1;
        for (int i = 0; i < 30 && n_deliv < snap + 6; i++) step();
        chk("t2_resume", 64'(n_deliv >= snap + 6), 64'd1);

        // Redirect with two requests in flight.
        do_reset();
        mem_delay = 3;
        step();
        step();
        chk("t3_two_inflight", 64'(n_acc), 64'd2);
        chk("t3_none_back", 64'(instr_valid), 64'd0);
        redirect_valid = 1'b1;
        redirect_pc    = 8'h40;
        step();
        redirect_valid = 1'b0;
        exp_pc         = 8'h40;
        chk("t3_new_addr", 64'(imem_req_addr), 64'h40);
        chk("t3_flushed", 64'(instr_valid), 64'd0);
        for (int i = 0; i < 40 && n_deliv < 2; i++) step();
        chk("t3_two_delivered", 64'(n_deliv >= 2), 64'd1);

        // Halt after pc 5 has been accepted, then redirect while halted.
        do_reset();
        mem_delay = 0;
        for (int i = 0; i < 30 && n_acc < 6; i++) step();
        chk("t5_issued", 64'(n_acc), 64'd6);
        halt        = 1'b1;
        ready_block = 1'b1;
        step();
        ready_block = 1'b0;
        for (int i = 0; i < 12; i++) begin
            step();
            chk("t5_no_req", 64'(imem_req_valid), 64'd0);
        end
        chk("t5_delivered", 64'(n_deliv), 64'd6);
        chk("t5_next_pc", 64'(exp_pc), 64'd6);
        redirect_valid = 1'b1;
        redirect_pc    = 8'h80;
        step();
        redirect_valid = 1'b0;
        chk("t5_redir_addr", 64'(imem_req_addr), 64'h80);
        chk("t5_redir_empty", 64'(instr_valid), 64'd0);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("t5_halt_no_req", 64'(imem_req_valid), 64'd0);
        end
        chk("t5_no_new_accept", 64'(n_acc), 64'd6);

        // Random traffic, then reset mid-stream and restart.
        do_reset();
        mem_rand  = 1'b1;
        mem_delay = 3;
        for (int i = 0; i < 40; i++) begin
            instr_ready = ($urandom_range(0, 1) == 1);
            step();
        end
        chk("t6_progress", 64'(n_deliv > 0), 64'd1);
        #2;
        do_reset();
        #1;
        chk("t6_restart_valid", 64'(imem_req_valid), 64'd1);
        chk("t6_restart_addr", 64'(imem_req_addr), 64'h00);
        instr_ready = 1'b1;
        for (int i = 0; i < 80 && n_deliv < 4; i++) step();
        chk("t6_restart_delivered", 64'(n_deliv >= 4), 64'd1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
